// File: rtl/modular_addition.sv
// Limb-serial modular adder: result = (A + B) mod p.
// Add pass over NL limbs, then one conditional-subtract pass.
module modular_addition #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int NL = WIDTH / LIMB;
  localparam int IW = (NL > 1) ? $clog2(NL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SUB,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] d_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             borrow;
  logic             cout;
  logic             last;

  logic [LIMB:0]    sum_l;
  logic [LIMB:0]    diff_l;
  logic [WIDTH-1:0] d_full;

  assign last = (idx == IW'(NL - 1));

  // One limb of the add and subtract passes, plus the completed difference
  always_comb begin
    sum_l  = {1'b0, a_q[idx*LIMB +: LIMB]}
           + {1'b0, b_q[idx*LIMB +: LIMB]}
           + {{LIMB{1'b0}}, carry};
    diff_l = {1'b0, s_q[idx*LIMB +: LIMB]}
           - {1'b0, p_q[idx*LIMB +: LIMB]}
           - {{LIMB{1'b0}}, borrow};
    d_full = d_q;
    d_full[idx*LIMB +: LIMB] = diff_l[LIMB-1:0];
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (i_start) state_nx = ADD;
      ADD:  if (last)    state_nx = SUB;
      SUB:  if (last)    state_nx = DONE;
      DONE: if (!i_start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, limb passes, final select and done flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result <= '0;
      done   <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
      cout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            a_q   <= A;
            b_q   <= B;
            p_q   <= p;
            carry <= 1'b0;
            idx   <= '0;
          end
        end
        ADD: begin
          s_q[idx*LIMB +: LIMB] <= sum_l[LIMB-1:0];
          carry <= sum_l[LIMB];
          if (last) begin
            cout   <= sum_l[LIMB];
            borrow <= 1'b0;
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SUB: begin
          d_q[idx*LIMB +: LIMB] <= diff_l[LIMB-1:0];
          borrow <= diff_l[LIMB];
          if (last) begin
            // Take the difference unless it went negative with no carry-out
            result <= (cout | ~diff_l[LIMB]) ? d_full : s_q;
            done   <= 1'b1;
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (!i_start) done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_addition.sv
// Randomized self-checking bench for modular_addition.
// Reference: (A+B) >= p ? (A+B-p) mod 2^W : A+B.
module tb_modular_addition;

  localparam int W = 256;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] p;
  logic [W-1:0] result;
  logic         done;

  int tests = 0;
  int fails = 0;

  localparam logic [W-1:0] SECP =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  modular_addition #(.WIDTH(W), .LIMB(64)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .A      (A),
    .B      (B),
    .p      (p),
    .result (result),
    .done   (done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) v = {v[W-33:0], $urandom()};
    return v;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [W-1:0] m);
    logic [W:0] s;
    logic [W:0] d;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) begin
      d = s - {1'b0, m};
      return d[W-1:0];
    end
    return s[W-1:0];
  endfunction

  // Run one op; optionally scramble operands during ADD and hold start.
  task automatic run_op(input string tag,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] m,
                        input bit scramble,
                        input int hold,
                        input bit chk_lat);
    logic [W-1:0] exp;
    int n;
    bit stable;
    exp = model(a, b, m);
    @(negedge i_clk);
    A = a;
    B = b;
    p = m;
    i_start = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      @(posedge i_clk);
      #1;
      n++;
      if (scramble && n == 2) begin
        A = rnd();
        B = rnd();
        p = rnd();
      end
    end
    if (chk_lat) check({tag, "_lat"}, W'(n), W'(9));
    check({tag, "_done"}, W'(done), W'(1));
    check({tag, "_res"}, result, exp);
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(posedge i_clk);
        #1;
        if (!done || result !== exp) stable = 1'b0;
      end
      check({tag, "_hold"}, W'(stable), W'(1));
    end
    @(negedge i_clk);
    i_start = 1'b0;
    @(posedge i_clk);
    #1;
    check({tag, "_drop"}, W'(done), W'(0));
    check({tag, "_kept"}, result, exp);
  endtask

  initial begin
    logic [W-1:0] m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    i_rst = 1'b1;
    i_start = 1'b0;
    A = '0;
    B = '0;
    p = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_done", W'(done), W'(0));
    check("rst_res", result, '0);
    @(negedge i_clk);
    i_rst = 1'b0;

    run_op("boundary", SECP + 1, '0, SECP, 0, 0, 1);
    check("boundary_one", result, W'(1));
    run_op("wrap", W'(8'hFF), W'(8'h20), W'(12'h100), 0, 0, 1);
    check("wrap_1f", result, W'(8'h1F));
    run_op("noreduce", W'(32'hDEADBEEF), W'(32'h02152412),
           W'(32'hFFFFFFFF), 0, 0, 1);
    check("noreduce_val", result, W'(32'hE0C2E301));
    run_op("exact", SECP - 1, W'(1), SECP, 0, 0, 1);
    check("exact_zero", result, '0);
    run_op("cout", SECP - 1, SECP - 1, SECP, 0, 0, 1);
    check("cout_pm2", result, SECP - 2);
    run_op("hold", rnd(), rnd(), SECP, 0, 50, 1);
    run_op("scram", SECP - 5, W'(7), SECP, 1, 0, 1);
    check("scram_val", result, W'(2));

    // Reset while in SUB discards the op
    @(negedge i_clk);
    A = rnd();
    B = rnd();
    p = SECP;
    i_start = 1'b1;
    repeat (6) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_start = 1'b0;
    @(posedge i_clk);
    #1;
    check("midrst_done", W'(done), W'(0));
    check("midrst_res", result, '0);
    @(negedge i_clk);
    i_rst = 1'b0;
    run_op("afterrst", SECP - 3, W'(10), SECP, 0, 0, 1);

    run_op("p0", rnd(), rnd(), '0, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      m = rnd();
      if (m == '0) m = W'(1);
      a = rnd() % m;
      b = rnd() % m;
      if (i % 5 == 4) a = rnd();
      run_op($sformatf("rnd%0d", i), a, b, m, (i % 3) == 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
